// File: rtl/tpu_pkg.sv
// tpu_pkg
// Shared definitions for the TPU load sequencer: the FSM state encoding,
// the default parameter constants and a small helper for sizing counters.
// No ports; imported by tpu_load_seq.
package tpu_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_N_DATA   = 16;
  localparam int DEF_N_WGT    = 16;
  localparam int DEF_WGT_BASE = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_D = 3'd1,
    LOAD_W = 3'd2,
    START  = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } tpu_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tpu_load_seq.sv
// tpu_load_seq
// Loads one job's worth of data words and weight words from a valid/ready
// stream into SRAM, then kicks the TPU core and waits for it to finish.
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   job_go                start a job (only looked at while idle)
//   in_valid, in_data     incoming word stream
//   in_ready              high while a word can be accepted
//   mem_we, mem_addr,
//   mem_wdata             registered SRAM write port, one cycle after accept
//   tpu_start             one-cycle start pulse to the TPU core
//   tpu_done              core completion (level or pulse), honoured in RUN only
//   busy                  high whenever a job is in progress
//   job_done              one-cycle pulse when the job finishes
module tpu_load_seq
  import tpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_DATA   = DEF_N_DATA,
  parameter int N_WGT    = DEF_N_WGT,
  parameter int WGT_BASE = DEF_WGT_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              tpu_start,
  input  logic              tpu_done,
  output logic              busy,
  output logic              job_done
);

  localparam int CNT_W = $clog2(max_int(N_DATA, N_WGT) + 1);

  localparam logic [CNT_W-1:0] LAST_D  = CNT_W'(N_DATA - 1);
  localparam logic [CNT_W-1:0] ALL_W   = CNT_W'(N_WGT);
  localparam logic [ADDR_W-1:0] W_BASE = ADDR_W'(WGT_BASE);

  tpu_state_e       state;
  tpu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_d_accept;
  logic             wgt_drained;

  // The weight counter is allowed to reach N_WGT after the final weight is
  // accepted. That one extra LOAD_W cycle, with in_ready low, is the cycle in
  // which the final SRAM write issues, so START never overlaps a write.
  assign in_ready      = (state == LOAD_D) || ((state == LOAD_W) && (cnt != ALL_W));
  assign accept        = in_valid & in_ready;
  assign last_d_accept = (state == LOAD_D) && accept && (cnt == LAST_D);
  assign wgt_drained   = (state == LOAD_W) && (cnt == ALL_W);

  assign tpu_start = (state == START);
  assign busy      = (state != IDLE);
  assign job_done  = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. job_go and tpu_done are only looked at in the one
  // state that cares about them, so requests arriving elsewhere are dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (job_go)        state_nxt = LOAD_D;
      LOAD_D:  if (last_d_accept) state_nxt = LOAD_W;
      LOAD_W:  if (wgt_drained)   state_nxt = START;
      START:                      state_nxt = RUN;
      RUN:     if (tpu_done)      state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Word counter: cleared on every state change so each load phase starts
  // from zero; otherwise it advances only on an accepted word, so stalls
  // (in_valid low) never skip an address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  // SRAM write port, registered one cycle behind the accept. Address and
  // data hold their last value between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_wdata <= in_data;
        if (state == LOAD_D) begin
          mem_addr <= ADDR_W'(cnt);
        end else begin
          mem_addr <= W_BASE + ADDR_W'(cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_tpu_load_seq.sv
// tb_tpu_load_seq
// Self-checking bench for tpu_load_seq. A default-parameter instance runs a
// table of whole jobs (back-to-back, toggling and random valid gaps, early
// tpu_done, job_go during RUN) against a job-level reference model; a second
// instance with N_DATA=4, N_WGT=2, WGT_BASE=8 checks the address map, and a
// hand-written sequence checks asynchronous reset in the middle of a load.
module tb_tpu_load_seq;

  localparam int DW   = 16;
  localparam int AW   = 10;
  localparam int ND   = 16;
  localparam int NW   = 16;
  localparam int WB   = 16;
  localparam int ND_B = 4;
  localparam int NW_B = 2;
  localparam int WB_B = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic          job_go, in_valid, tpu_done;
  logic [DW-1:0] in_data;
  logic          in_ready, mem_we, tpu_start, busy, job_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  logic          job_go_b, in_valid_b, tpu_done_b;
  logic [DW-1:0] in_data_b;
  logic          in_ready_b, mem_we_b, tpu_start_b, busy_b, job_done_b;
  logic [AW-1:0] mem_addr_b;
  logic [DW-1:0] mem_wdata_b;

  tpu_load_seq #(
    .DATA_W(DW), .ADDR_W(AW), .N_DATA(ND), .N_WGT(NW), .WGT_BASE(WB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .job_go(job_go), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .tpu_start(tpu_start),
    .tpu_done(tpu_done), .busy(busy), .job_done(job_done)
  );

  tpu_load_seq #(
    .DATA_W(DW), .ADDR_W(AW), .N_DATA(ND_B), .N_WGT(NW_B), .WGT_BASE(WB_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .job_go(job_go_b), .in_valid(in_valid_b),
    .in_data(in_data_b), .in_ready(in_ready_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .tpu_start(tpu_start_b),
    .tpu_done(tpu_done_b), .busy(busy_b), .job_done(job_done_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t wr_q[$];
  wr_t exp_q[$];
  wr_t wrb_q[$];
  int  start_q[$];
  int  jd_q[$];
  int  startb_q[$];
  int  jdb_q[$];

  // Observe both instances mid-cycle and log every write and pulse with the
  // cycle it appeared in.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we === 1'b1) begin
      w.c = cyc; w.a = mem_addr; w.d = mem_wdata;
      wr_q.push_back(w);
    end
    if (tpu_start === 1'b1) start_q.push_back(cyc);
    if (job_done === 1'b1)  jd_q.push_back(cyc);
    if (mem_we_b === 1'b1) begin
      w.c = cyc; w.a = mem_addr_b; w.d = mem_wdata_b;
      wrb_q.push_back(w);
    end
    if (tpu_start_b === 1'b1) startb_q.push_back(cyc);
    if (job_done_b === 1'b1)  jdb_q.push_back(cyc);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word k of a job lands at k for data, then WGT_BASE onward for weights.
  function automatic int addr_of(input int k, input int nd, input int wb);
    return (k < nd) ? k : wb + (k - nd);
  endfunction

  typedef struct {
    int            gap_mode;
    bit            early_done;
    bit            go_in_run;
    logic [DW-1:0] base;
    int            exp_writes;
    int            exp_first_addr;
    int            exp_last_addr;
    int            exp_job_done;
  } job_vec_t;

  // Runs one complete job on the default instance and compares everything
  // it produced against the job-level model.
  task automatic applyStimulus(input job_vec_t v, input int idx);
    int            k;
    int            i;
    int            last_cyc;
    int            s_cyc;
    int            done_cyc;
    bit            send;
    logic [DW-1:0] w;
    wr_t           e;
    wr_q.delete(); exp_q.delete(); start_q.delete(); jd_q.delete();
    @(posedge clk); #1;
    job_go = 1'b1;
    @(posedge clk); #1;
    job_go = 1'b0;
    k = 0; i = 0; last_cyc = 0;
    while (k < ND + NW && i < 2000) begin
      case (v.gap_mode)
        1:       send = (i % 2 == 0);
        2:       send = ($urandom_range(0, 2) != 0);
        default: send = 1'b1;
      endcase
      tpu_done = v.early_done && (k == ND + 4);
      in_valid = send;
      if (send) begin
        w       = v.base + DW'(k);
        in_data = w;
        e.c = cyc + 1; e.a = AW'(addr_of(k, ND, WB)); e.d = w;
        exp_q.push_back(e);
        last_cyc = cyc + 1;
        k++;
      end else begin
        in_data = DW'($urandom);
      end
      i++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tpu_done = 1'b0;
    if (k != ND + NW) begin
      n_cmp++; n_bad++;
      $display("[TB] FAIL v%0d_feed_budget: sent %0d words, expected %0d", idx, k, ND + NW);
    end
    s_cyc    = last_cyc + 1;
    done_cyc = s_cyc + 5;
    while (cyc < done_cyc + 4) begin
      job_go   = v.go_in_run && (cyc == s_cyc + 2);
      tpu_done = (cyc == done_cyc);
      @(posedge clk); #1;
    end
    job_go   = 1'b0;
    tpu_done = 1'b0;

    checkOutput($sformatf("v%0d_write_count", idx), wr_q.size(), v.exp_writes);
    if (wr_q.size() > 0) begin
      checkOutput($sformatf("v%0d_first_addr", idx), wr_q[0].a, v.exp_first_addr);
      checkOutput($sformatf("v%0d_last_addr", idx), wr_q[wr_q.size()-1].a, v.exp_last_addr);
    end
    for (int j = 0; j < wr_q.size() && j < exp_q.size(); j++) begin
      checkOutput($sformatf("v%0d_w%0d_cycle", idx, j), wr_q[j].c, exp_q[j].c);
      checkOutput($sformatf("v%0d_w%0d_addr", idx, j), wr_q[j].a, exp_q[j].a);
      checkOutput($sformatf("v%0d_w%0d_data", idx, j), wr_q[j].d, exp_q[j].d);
    end
    checkOutput($sformatf("v%0d_start_count", idx), start_q.size(), 1);
    if (start_q.size() > 0)
      checkOutput($sformatf("v%0d_start_cycle", idx), start_q[0], s_cyc);
    checkOutput($sformatf("v%0d_job_done_count", idx), jd_q.size(), v.exp_job_done);
    if (jd_q.size() > 0)
      checkOutput($sformatf("v%0d_job_done_cycle", idx), jd_q[0], done_cyc + 1);
    checkOutput($sformatf("v%0d_busy_after", idx), busy, 0);
    checkOutput($sformatf("v%0d_ready_after", idx), in_ready, 0);
  endtask

  job_vec_t vecs[6];

  initial begin
    int last_b;
    int exp_b_addr[6];
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int last_b;
    int exp_b_addr[6];

    //           gap early go_run base                  writes first last jd
    vecs[0] = '{0, 1'b0, 1'b0, 16'h0001,               32, 0, 31, 1};
    vecs[1] = '{1, 1'b0, 1'b0, 16'h0001,               32, 0, 31, 1};
    vecs[2] = '{0, 1'b1, 1'b0, 16'h0101,               32, 0, 31, 1};
    vecs[3] = '{0, 1'b0, 1'b1, 16'h0201,               32, 0, 31, 1};
    vecs[4] = '{2, 1'b0, 1'b0, DW'($urandom),          32, 0, 31, 1};
    vecs[5] = '{2, 1'b1, 1'b1, DW'($urandom),          32, 0, 31, 1};
    exp_b_addr = '{0, 1, 2, 3, 8, 9};

    rst_n = 1'b0;
    job_go = 1'b0; in_valid = 1'b0; in_data = '0; tpu_done = 1'b0;
    job_go_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; tpu_done_b = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_mem_we", mem_we, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_wdata", mem_wdata, 0);
    checkOutput("reset_tpu_start", tpu_start, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_job_done", job_done, 0);
    checkOutput("reset_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      $display("[TB] job vector %0d", v);
      applyStimulus(vecs[v], v);
    end

    // Reset in the middle of the data phase, right as the 10th write issues.
    $display("[TB] reset mid-job");
    @(posedge clk); #1;
    job_go = 1'b1;
    @(posedge clk); #1;
    job_go = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(16'h0100 + k);
      @(posedge clk); #1;
    end
    checkOutput("rst_pre_mem_we", mem_we, 1);
    checkOutput("rst_pre_addr", mem_addr, 9);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_in_ready", in_ready, 0);
    checkOutput("rst_async_mem_we", mem_we, 0);
    checkOutput("rst_async_mem_addr", mem_addr, 0);
    checkOutput("rst_async_mem_wdata", mem_wdata, 0);
    checkOutput("rst_async_tpu_start", tpu_start, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_job_done", job_done, 0);
    wr_q.delete(); start_q.delete(); jd_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      tpu_done = (k == 30);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tpu_done = 1'b0;
    checkOutput("rst_after_writes", wr_q.size(), 0);
    checkOutput("rst_after_starts", start_q.size(), 0);
    checkOutput("rst_after_job_done", jd_q.size(), 0);
    checkOutput("rst_after_busy", busy, 0);

    // job_go in the very first cycle after reset release is honoured.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    job_go = 1'b1;
    @(posedge clk); #1;
    job_go = 1'b0;
    checkOutput("go_after_release_busy", busy, 1);
    checkOutput("go_after_release_ready", in_ready, 1);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small configuration: address map and start timing.
    $display("[TB] small configuration instance");
    wrb_q.delete(); startb_q.delete(); jdb_q.delete();
    job_go_b = 1'b1;
    @(posedge clk); #1;
    job_go_b = 1'b0;
    last_b = 0;
    for (int k = 0; k < ND_B + NW_B; k++) begin
      in_valid_b = 1'b1;
      in_data_b  = DW'(16'hA000 + k);
      last_b     = cyc + 1;
      @(posedge clk); #1;
    end
    in_valid_b = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    tpu_done_b = 1'b1;
    @(posedge clk); #1;
    tpu_done_b = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("b_write_count", wrb_q.size(), 6);
    for (int j = 0; j < wrb_q.size() && j < 6; j++) begin
      checkOutput($sformatf("b_w%0d_addr", j), wrb_q[j].a, exp_b_addr[j]);
      checkOutput($sformatf("b_w%0d_data", j), wrb_q[j].d, 16'hA000 + j);
    end
    checkOutput("b_start_count", startb_q.size(), 1);
    if (startb_q.size() > 0)
      checkOutput("b_start_cycle", startb_q[0], last_b + 1);
    checkOutput("b_job_done_count", jdb_q.size(), 1);
    checkOutput("b_busy_after", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_load_seq.md
TPU_LOAD_SEQ -- requirements
Module: tpu_load_seq

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set word width of loaded data and weights.
REQ-002 Parameter ADDR_W, default 10, SHALL set SRAM address width.
REQ-003 Parameter N_DATA, default 16, SHALL set the number of data words per job.
REQ-004 Parameter N_WGT, default 16, SHALL set the number of weight words per job.
REQ-005 Parameter WGT_BASE, default 16, SHALL set the first SRAM address for weights.
REQ-006 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 job_go  input  1  SHALL request a new load-and-run job; sampled only in IDLE.
REQ-009 in_valid  input  1  SHALL qualify in_data.
REQ-010 in_data  input  DATA_W  SHALL carry the next data or weight word.
REQ-011 in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-012 mem_we  output  1  SHALL be the SRAM write strobe, one cycle per word.
REQ-013 mem_addr  output  ADDR_W  SHALL be the SRAM write address.
REQ-014 mem_wdata  output  DATA_W  SHALL be the SRAM write data.
REQ-015 tpu_start  output  1  SHALL be a one-cycle start pulse to the TPU core.
REQ-016 tpu_done  input  1  SHALL be the TPU core completion indication (level or pulse).
REQ-017 busy  output  1  SHALL be high in every state except IDLE.
REQ-018 job_done  output  1  SHALL pulse one cycle when a job completes.

Function
REQ-019 FSM states SHALL be IDLE, LOAD_D, LOAD_W, START, RUN, DONE.
REQ-020 IDLE -> LOAD_D on job_go=1; otherwise remain; in_ready=0 in IDLE.
REQ-021 In LOAD_D/LOAD_W in_ready SHALL be 1; a word is accepted on a cycle with in_valid&in_ready.
REQ-022 Each accepted word SHALL produce mem_we=1 with registered mem_addr/mem_wdata on the next cycle (latency 1).
REQ-023 LOAD_D addresses SHALL be 0..N_DATA-1 in order; LOAD_W addresses WGT_BASE..WGT_BASE+N_WGT-1 in order.
REQ-024 in_valid=0 SHALL stall the counter with mem_we=0; no bubbles are written.
REQ-025 Acceptance of word N_DATA-1 SHALL move LOAD_D -> LOAD_W; word N_WGT-1 SHALL move LOAD_W -> START; in_ready SHALL drop in the cycle after the last accept.
REQ-026 START SHALL last exactly one cycle with tpu_start=1, entered only after the final mem_we cycle has issued, then -> RUN.
REQ-027 RUN SHALL wait for tpu_done=1, then -> DONE; tpu_done outside RUN SHALL be ignored.
REQ-028 DONE SHALL last one cycle with job_done=1, then -> IDLE.
REQ-029 job_go while busy SHALL be ignored (no queueing).
REQ-030 Word counter SHALL be sized $clog2 of max(N_DATA,N_WGT)+1 and reset to 0 on each state entry of LOAD_D/LOAD_W.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, counter 0, and in_ready, mem_we, tpu_start, busy, job_done to 0, mem_addr and mem_wdata to 0.
REQ-032 Reset mid-job SHALL abandon the job with no further SRAM writes or tpu_start; partial SRAM contents are not cleared.
REQ-033 Reset release SHALL need no additional cycles before job_go is honoured.

Structure
REQ-034 State encoding and default parameter constants SHALL live in shared package tpu_pkg.
REQ-035 Block SHALL be a single module with no sub-modules; counter and address generation inline.

Verification
REQ-036 Reset, job_go=1, 32 back-to-back valid words 0x0001..0x0020 -> mem_we on 32 consecutive cycles, addr 0..31, data 0x0001..0x0020, tpu_start one cycle after last mem_we.
REQ-037 in_valid toggling 1/0 every cycle during load -> 32 writes at same addresses/data, no write when in_valid=0, counter never skips.
REQ-038 tpu_done asserted during LOAD_W and later 5 cycles after tpu_start -> early done ignored; job_done pulses once one cycle after the second tpu_done, then busy=0.
REQ-039 job_go pulsed while in RUN -> no new load; after job_done a fresh job_go restarts at address 0.
REQ-040 rst_n=0 after 10 data words accepted -> all outputs 0 immediately (asynchronous), state IDLE, no tpu_start afterwards.
REQ-041 N_DATA=4, N_WGT=2, WGT_BASE=8 -> writes to addresses 0,1,2,3,8,9 only, then tpu_start.
